// File: rtl/spi_pkg.sv
// Shared constants, FSM state type and CRC-8 step function for the SPI frame master.
package spi_pkg;

  localparam logic [7:0] CRC8_POLY  = 8'h1D;
  localparam logic [7:0] CRC8_INIT  = 8'hFF;
  localparam int         FRAME_BITS = 32;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    SHIFT = 3'd2,
    HOLD  = 3'd3,
    DONE  = 3'd4
  } spi_state_e;

  // One MSB-first serial step of CRC-8, poly 0x1D, no reflection.
  function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic bit_in);
    logic fb;
    fb = crc[7] ^ bit_in;
    return {crc[6:0], 1'b0} ^ (fb ? CRC8_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/spi_crc8_serial.sv
// Bit-serial CRC-8 accumulator; clear reloads the init value for a new frame.
module spi_crc8_serial
  import spi_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       bit_valid,
  input  logic       bit_in,
  output logic [7:0] crc_out
);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      crc_out <= CRC8_INIT;
    end else if (bit_valid) begin
      crc_out <= crc8_step(crc_out, bit_in);
    end
  end

endmodule

// File: rtl/spi_frame_master.sv
// SPI master sending a 24-bit payload plus CRC-8 per 32-bit frame and checking the
// CRC of the simultaneously received response. Handshake: a word moves when tx_valid && tx_ready at a clk edge.
module spi_frame_master
  import spi_pkg::*;
#(
  parameter int CLK_DIV  = 4,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2,
  parameter int DATA_W   = 24,
  parameter int CRC_W    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tx_valid,
  output logic              tx_ready,
  input  logic [DATA_W-1:0] tx_data,
  output logic              rx_valid,
  output logic [DATA_W-1:0] rx_data,
  output logic [CRC_W-1:0]  rx_crc,
  output logic              rx_crc_ok,
  output logic              busy,
  output logic              sck,
  output logic              csn,
  output logic              mosi,
  input  logic              miso
);

  localparam int SLOT   = 2 * CLK_DIV;
  localparam int CNT_W  = 16;
  localparam int BIT_W  = $clog2(FRAME_BITS);
  localparam int DSEL_W = $clog2(DATA_W);

  spi_state_e        state, state_next;
  logic [CNT_W-1:0]  cnt;
  logic [BIT_W-1:0]  bit_cnt;
  logic [BIT_W-1:0]  next_idx;
  logic [DSEL_W-1:0] dsel;
  logic [DATA_W-1:0] tx_word;
  logic [FRAME_BITS-1:0] rx_shift;
  logic [7:0]        tx_crc;
  logic [7:0]        rx_crc_calc;
  logic              handshake, slot_fall, slot_end, last_slot, slot_rise;
  logic              next_is_data, next_bit;

  assign handshake = (state == IDLE) && tx_valid;
  assign slot_fall = (state == SHIFT) && (cnt == CNT_W'(CLK_DIV - 1));
  assign slot_end  = (state == SHIFT) && (cnt == CNT_W'(SLOT - 1));
  assign last_slot = (bit_cnt == BIT_W'(FRAME_BITS - 1));
  assign slot_rise = ((state == SETUP) && (state_next == SHIFT)) || (slot_end && !last_slot);

  // Bit index that the coming rising edge puts on mosi: payload first, then the tx CRC.
  assign next_idx     = (state == SETUP) ? '0 : bit_cnt + 1'b1;
  assign next_is_data = next_idx < BIT_W'(DATA_W);
  assign dsel         = DSEL_W'(BIT_W'(DATA_W - 1) - next_idx);
  assign next_bit     = next_is_data ? tx_word[dsel] : tx_crc[~next_idx[2:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (tx_valid) state_next = SETUP;
      SETUP:   if (cnt == CNT_W'(CS_SETUP - 1)) state_next = SHIFT;
      SHIFT:   if (slot_end && last_slot) state_next = HOLD;
      HOLD:    if (cnt == CNT_W'(CS_HOLD - 1)) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    tx_ready = (state == IDLE);
    busy     = (state != IDLE);
    csn      = !((state == SETUP) || (state == SHIFT) || (state == HOLD));
    rx_valid = (state == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      bit_cnt   <= '0;
      sck       <= 1'b0;
      mosi      <= 1'b0;
      tx_word   <= '0;
      rx_shift  <= '0;
      rx_data   <= '0;
      rx_crc    <= '0;
      rx_crc_ok <= 1'b0;
    end else begin
      // One counter serves setup, the sck divider within a slot, and hold.
      if ((state == IDLE) || (state_next != state) || slot_end) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end

      if (handshake) tx_word <= tx_data;

      if (state == SETUP) begin
        bit_cnt <= '0;
      end else if (slot_end && !last_slot) begin
        bit_cnt <= bit_cnt + 1'b1;
      end

      if (slot_rise) begin
        sck  <= 1'b1;
        mosi <= next_bit;
      end else if (slot_fall) begin
        sck      <= 1'b0;
        rx_shift <= {rx_shift[FRAME_BITS-2:0], miso};
      end

      if (state == DONE) mosi <= 1'b0;

      if ((state == HOLD) && (state_next == DONE)) begin
        rx_data   <= rx_shift[FRAME_BITS-1 -: DATA_W];
        rx_crc    <= rx_shift[CRC_W-1:0];
        rx_crc_ok <= (rx_crc_calc == rx_shift[CRC_W-1:0]);
      end
    end
  end

  spi_crc8_serial u_tx_crc (
    .clk       (clk),
    .rst       (rst),
    .clear     (handshake),
    .bit_valid (slot_rise && next_is_data),
    .bit_in    (next_bit),
    .crc_out   (tx_crc)
  );

  spi_crc8_serial u_rx_crc (
    .clk       (clk),
    .rst       (rst),
    .clear     (handshake),
    .bit_valid (slot_fall && (bit_cnt < BIT_W'(DATA_W))),
    .bit_in    (miso),
    .crc_out   (rx_crc_calc)
  );

endmodule

// File: tb/tb_spi_frame_master.sv
// Directed bench for spi_frame_master: pin timing, loopback CRC, error injection, back-to-back and reset abort.
module tb_spi_frame_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        tx_valid;
  logic        tx_ready;
  logic [23:0] tx_data;
  logic        rx_valid;
  logic [23:0] rx_data;
  logic [7:0]  rx_crc;
  logic        rx_crc_ok;
  logic        busy;
  logic        sck;
  logic        csn;
  logic        mosi;
  logic        miso;

  int tests = 0;
  int fails = 0;

  int miso_mode = 1;
  int inv_slot  = -1;

  int low_cnt = 0, high_cnt = 0, last_gap = 0, frame_len = 0;
  int rises = 0, first_off = -1, last_rise = 0, period_err = 0, mosi_err = 0;
  int sck_csn_err = 0, ready_err = 0, rxv_cnt = 0, rxv_pos_err = 0, hs_cnt = 0;
  logic [31:0] mosi_bits = '0;
  logic sck_p = 1'b0, csn_p = 1'b1, mosi_p = 1'b0;

  spi_frame_master dut (
    .clk       (clk),
    .rst       (rst),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .tx_data   (tx_data),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .rx_crc    (rx_crc),
    .rx_crc_ok (rx_crc_ok),
    .busy      (busy),
    .sck       (sck),
    .csn       (csn),
    .mosi      (mosi),
    .miso      (miso)
  );

  always #5 clk = ~clk;

  assign miso = (miso_mode == 0) ? 1'b0 : (mosi ^ ((inv_slot >= 0) && (rises == inv_slot + 1)));

  always @(posedge clk) begin
    if (tx_valid && tx_ready && !rst) hs_cnt++;
  end

  always @(negedge clk) begin
    if (csn_p && !csn) begin
      low_cnt = 0; rises = 0; first_off = -1; period_err = 0; mosi_err = 0;
      mosi_bits = '0; last_gap = high_cnt; high_cnt = 0;
    end
    if (!csn) low_cnt++;
    else high_cnt++;
    if (!csn_p && csn) frame_len = low_cnt;
    if (sck && !sck_p) begin
      rises++;
      if (rises == 1) first_off = low_cnt - 1;
      else if (low_cnt - last_rise != 8) period_err++;
      last_rise = low_cnt;
      mosi_bits = {mosi_bits[30:0], mosi};
    end
    if (!sck && sck_p && (mosi !== mosi_p)) mosi_err++;
    if (sck && csn) sck_csn_err++;
    if (busy && tx_ready) ready_err++;
    if (rx_valid) begin
      rxv_cnt++;
      if (!(csn && !csn_p)) rxv_pos_err++;
    end
    sck_p = sck; csn_p = csn; mosi_p = mosi;
  end

  task automatic wait_ready();
    bit ok = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (tx_ready) begin ok = 1; break; end
    end
    tests++;
    if (!ok) begin fails++; $display("FAIL tx_ready_timeout got=0 want=1"); end
  endtask

  task automatic wait_rx();
    bit ok = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (rx_valid) begin ok = 1; break; end
    end
    tests++;
    if (!ok) begin fails++; $display("FAIL rx_valid_timeout got=0 want=1"); end
    #1;
  endtask

  task automatic send(input logic [23:0] d);
    wait_ready();
    tx_valid = 1'b1;
    tx_data  = d;
    @(negedge clk);
    tx_valid = 1'b0;
    tx_data  = 24'($urandom_range(0, 32'h00FF_FFFF));
  endtask

  task automatic run_frame(input logic [23:0] d);
    send(d);
    wait_rx();
  endtask

  task automatic test_reset();
    rst = 1'b1; tx_valid = 1'b1; tx_data = 24'h123456;
    repeat (3) @(posedge clk);
    #1;
    tests++; if (sck !== 1'b0) begin fails++; $display("FAIL reset_sck got=%b want=0", sck); end
    tests++; if (csn !== 1'b1) begin fails++; $display("FAIL reset_csn got=%b want=1", csn); end
    tests++; if (mosi !== 1'b0) begin fails++; $display("FAIL reset_mosi got=%b want=0", mosi); end
    tests++; if (rx_valid !== 1'b0) begin fails++; $display("FAIL reset_rx_valid got=%b want=0", rx_valid); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got=%b want=0", busy); end
    tests++; if (tx_ready !== 1'b1) begin fails++; $display("FAIL reset_tx_ready got=%b want=1", tx_ready); end
    tests++; if (rx_data !== 24'h0) begin fails++; $display("FAIL reset_rx_data got=%h want=000000", rx_data); end
    tests++; if (rx_crc !== 8'h0) begin fails++; $display("FAIL reset_rx_crc got=%h want=00", rx_crc); end
    tests++; if (rx_crc_ok !== 1'b0) begin fails++; $display("FAIL reset_rx_crc_ok got=%b want=0", rx_crc_ok); end
    @(negedge clk);
    tx_valid = 1'b0;
    rst = 1'b0;
  endtask

  task automatic test_timing();
    miso_mode = 1;
    run_frame(24'h123456);
    tests++; if (frame_len != 260) begin fails++; $display("FAIL timing_csn_low got=%0d want=260", frame_len); end
    tests++; if (rises != 32) begin fails++; $display("FAIL timing_sck_rises got=%0d want=32", rises); end
    tests++; if (first_off != 2) begin fails++; $display("FAIL timing_first_rise got=%0d want=2", first_off); end
    tests++; if (period_err != 0) begin fails++; $display("FAIL timing_sck_period errors=%0d want=0", period_err); end
    tests++; if (mosi_err != 0) begin fails++; $display("FAIL timing_mosi_stable errors=%0d want=0", mosi_err); end
    tests++; if (sck_csn_err != 0) begin fails++; $display("FAIL timing_sck_while_csn errors=%0d want=0", sck_csn_err); end
    tests++; if (rx_data !== 24'h123456) begin fails++; $display("FAIL timing_rx_data got=%h want=123456", rx_data); end
    tests++; if (rx_crc_ok !== 1'b1) begin fails++; $display("FAIL timing_rx_crc_ok got=%b want=1", rx_crc_ok); end
  endtask

  task automatic test_loopback_zero();
    int base;
    miso_mode = 1;
    base = rxv_cnt;
    run_frame(24'h000000);
    tests++; if (mosi_bits[7:0] !== 8'h0E) begin fails++; $display("FAIL lb0_mosi_crc got=%h want=0e", mosi_bits[7:0]); end
    tests++; if (rx_data !== 24'h0) begin fails++; $display("FAIL lb0_rx_data got=%h want=000000", rx_data); end
    tests++; if (rx_crc !== 8'h0E) begin fails++; $display("FAIL lb0_rx_crc got=%h want=0e", rx_crc); end
    tests++; if (rx_crc_ok !== 1'b1) begin fails++; $display("FAIL lb0_rx_crc_ok got=%b want=1", rx_crc_ok); end
    repeat (4) @(negedge clk);
    #1;
    tests++; if (rxv_cnt - base != 1) begin fails++; $display("FAIL lb0_rx_valid_count got=%0d want=1", rxv_cnt - base); end
    tests++; if (rxv_pos_err != 0) begin fails++; $display("FAIL lb0_rx_valid_position errors=%0d want=0", rxv_pos_err); end
  endtask

  task automatic test_slot5_invert();
    miso_mode = 1;
    inv_slot = 5;
    run_frame(24'hA5A5A5);
    inv_slot = -1;
    tests++; if (rx_data !== 24'hA1A5A5) begin fails++; $display("FAIL inv5_rx_data got=%h want=a1a5a5", rx_data); end
    tests++; if (rx_crc_ok !== 1'b0) begin fails++; $display("FAIL inv5_rx_crc_ok got=%b want=0", rx_crc_ok); end
  endtask

  task automatic test_miso_zero();
    miso_mode = 0;
    run_frame(24'h5A5A5A);
    miso_mode = 1;
    tests++; if (rx_data !== 24'h0) begin fails++; $display("FAIL miso0_rx_data got=%h want=000000", rx_data); end
    tests++; if (rx_crc !== 8'h00) begin fails++; $display("FAIL miso0_rx_crc got=%h want=00", rx_crc); end
    tests++; if (rx_crc_ok !== 1'b0) begin fails++; $display("FAIL miso0_rx_crc_ok got=%b want=0", rx_crc_ok); end
  endtask

  task automatic test_back_to_back();
    int hs_base;
    bit ok;
    miso_mode = 1;
    wait_ready();
    hs_base = hs_cnt;
    ready_err = 0;
    tx_valid = 1'b1;
    tx_data  = 24'h0F0F0F;
    @(negedge clk);
    tx_data  = 24'hC3C3C3;
    wait_rx();
    tests++; if (rx_data !== 24'h0F0F0F) begin fails++; $display("FAIL b2b_first_data got=%h want=0f0f0f", rx_data); end
    tests++; if (hs_cnt - hs_base != 1) begin fails++; $display("FAIL b2b_hs_in_frame1 got=%0d want=1", hs_cnt - hs_base); end
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (busy) begin ok = 1; break; end
    end
    tx_valid = 1'b0;
    tests++; if (!ok) begin fails++; $display("FAIL b2b_second_start got=0 want=1"); end
    wait_rx();
    tests++; if (rx_data !== 24'hC3C3C3) begin fails++; $display("FAIL b2b_second_data got=%h want=c3c3c3", rx_data); end
    tests++; if (hs_cnt - hs_base != 2) begin fails++; $display("FAIL b2b_hs_total got=%0d want=2", hs_cnt - hs_base); end
    tests++; if (last_gap != 2) begin fails++; $display("FAIL b2b_csn_gap got=%0d want=2", last_gap); end
    tests++; if (ready_err != 0) begin fails++; $display("FAIL b2b_ready_in_frame errors=%0d want=0", ready_err); end
  endtask

  task automatic test_reset_mid_shift();
    int rxv_base;
    bit ok = 0;
    miso_mode = 1;
    send(24'h123456);
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      #1;
      if (rises >= 11) begin ok = 1; break; end
    end
    tests++; if (!ok) begin fails++; $display("FAIL rst_mid_reach_slot10 got=0 want=1"); end
    rst = 1'b1;
    rxv_base = rxv_cnt;
    @(posedge clk);
    #1;
    tests++; if (sck !== 1'b0) begin fails++; $display("FAIL rst_mid_sck got=%b want=0", sck); end
    tests++; if (csn !== 1'b1) begin fails++; $display("FAIL rst_mid_csn got=%b want=1", csn); end
    tests++; if (mosi !== 1'b0) begin fails++; $display("FAIL rst_mid_mosi got=%b want=0", mosi); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rst_mid_busy got=%b want=0", busy); end
    tests++; if (tx_ready !== 1'b1) begin fails++; $display("FAIL rst_mid_tx_ready got=%b want=1", tx_ready); end
    @(negedge clk);
    rst = 1'b0;
    repeat (400) @(negedge clk);
    #1;
    tests++; if (rxv_cnt != rxv_base) begin fails++; $display("FAIL rst_mid_no_rx_valid got=%0d want=0", rxv_cnt - rxv_base); end
    run_frame(24'h000000);
    tests++; if (rx_data !== 24'h0) begin fails++; $display("FAIL rst_mid_after_rx_data got=%h want=000000", rx_data); end
    tests++; if (rx_crc !== 8'h0E) begin fails++; $display("FAIL rst_mid_after_rx_crc got=%h want=0e", rx_crc); end
    tests++; if (rx_crc_ok !== 1'b1) begin fails++; $display("FAIL rst_mid_after_rx_crc_ok got=%b want=1", rx_crc_ok); end
  endtask

  initial begin
    rst = 1'b1;
    tx_valid = 1'b0;
    tx_data = '0;
    test_reset();
    test_timing();
    test_loopback_zero();
    test_slot5_invert();
    test_miso_zero();
    test_back_to_back();
    test_reset_mid_shift();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
